// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_phy_pkg
//  Description : Shared symbol constant, lane-sync state encoding and a
//                counter-width helper for the receive lane sync logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    // Alignment / filler symbol recognised on the receive lane.
    localparam logic [7:0] COM_SYMBOL = 8'hBC;

    // Lane synchronisation states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        ACQUIRE = 2'd2,
        LOCKED  = 2'd3
    } lane_state_e;

    // Bits needed to hold the value max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_sym_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_sym_timer
//  Description : Byte-qualified up-counter. Counts enabled bytes and raises a
//                combinational terminal pulse on the MAX-th byte, clearing
//                itself on that same byte. Synchronous clear has priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_sym_timer
    import pcie_phy_pkg::*;
#(
    parameter int MAX = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int             W    = cnt_width(MAX);
    localparam logic [W-1:0]   LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count and terminal pulse; the MAX-th byte wraps the count to zero.
    always_comb begin
        cnt_d = cnt_q;
        tc_o  = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tc_o  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_lane_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_lane_sync_ctrl
//  Description : Receive lane sync controller. Hunts for COM alignment with
//                bit-slip requests, acquires lock after a run of COMs,
//                forwards payload while stripping COM filler, and drops lock
//                when COMs stop recurring.
//  Options     : RX_SYNC_STATS_EN adds saturating slip_cnt / loss_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_lane_sync_ctrl
    import pcie_phy_pkg::*;
#(
    parameter int ACQ_COUNT    = 4,
    parameter int HUNT_TIMEOUT = 16,
    parameter int COM_INTERVAL = 64,
    parameter int LOSS_COUNT   = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       slip_req,
    output logic       active,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lock_lost
`ifdef RX_SYNC_STATS_EN
    ,
    output logic [7:0] slip_cnt,
    output logic [7:0] loss_cnt
`endif
);

    localparam int           CW           = cnt_width(ACQ_COUNT);
    localparam int           MW           = cnt_width(LOSS_COUNT);
    localparam logic [CW-1:0] ACQ_LAST_M1  = CW'(ACQ_COUNT - 1);
    localparam logic [MW-1:0] LOSS_LAST_M1 = MW'(LOSS_COUNT - 1);

    lane_state_e   state_q, state_d;
    logic [CW-1:0] com_cnt_q, com_cnt_d;
    logic [MW-1:0] miss_cnt_q, miss_cnt_d;
    logic          slip_q, slip_d;
    logic          lost_q, lost_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;

    logic w_is_com;
    logic w_take;
    logic w_hunt_en, w_hunt_clr, w_hunt_tc;
    logic w_gap_en, w_gap_clr, w_gap_tc;

    assign w_is_com = (byte_in == COM_SYMBOL);
    assign w_take   = rx_enable && byte_valid;

    // HUNT timer counts non-COM bytes; any COM or leaving HUNT restarts it.
    assign w_hunt_en  = (state_q == HUNT) && w_take && !w_is_com;
    assign w_hunt_clr = (state_q != HUNT) || !rx_enable || (byte_valid && w_is_com);

    // LOCKED gap timer measures bytes since the last COM.
    assign w_gap_en  = (state_q == LOCKED) && w_take && !w_is_com;
    assign w_gap_clr = (state_q != LOCKED) || !rx_enable || (byte_valid && w_is_com);

    rx_sym_timer #(
        .MAX (HUNT_TIMEOUT)
    ) u_hunt_timer (
        .clk_i (clk_4f),
        .rst_i (reset),
        .clr_i (w_hunt_clr),
        .en_i  (w_hunt_en),
        .tc_o  (w_hunt_tc)
    );

    rx_sym_timer #(
        .MAX (COM_INTERVAL)
    ) u_gap_timer (
        .clk_i (clk_4f),
        .rst_i (reset),
        .clr_i (w_gap_clr),
        .en_i  (w_gap_en),
        .tc_o  (w_gap_tc)
    );

    // Next-state, counters and registered-output decisions.
    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        miss_cnt_d = miss_cnt_q;
        slip_d     = 1'b0;
        lost_d     = 1'b0;
        valid_d    = 1'b0;
        data_d     = data_q;

        if (!rx_enable) begin
            // Disable overrides everything, including a byte on this cycle.
            state_d    = IDLE;
            com_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = HUNT;
                end
                HUNT: begin
                    if (byte_valid) begin
                        if (w_is_com) begin
                            if (ACQ_COUNT == 1) begin
                                state_d   = LOCKED;
                                com_cnt_d = '0;
                            end else begin
                                state_d   = ACQUIRE;
                                com_cnt_d = CW'(1);
                            end
                        end else if (w_hunt_tc) begin
                            slip_d = 1'b1;
                        end
                    end
                end
                ACQUIRE: begin
                    if (byte_valid) begin
                        if (w_is_com) begin
                            if (com_cnt_q == ACQ_LAST_M1) begin
                                state_d   = LOCKED;
                                com_cnt_d = '0;
                            end else begin
                                com_cnt_d = com_cnt_q + 1'b1;
                            end
                        end else begin
                            // Broken run: retry the hunt without slipping.
                            state_d   = HUNT;
                            com_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (byte_valid) begin
                        if (w_is_com) begin
                            miss_cnt_d = '0;
                        end else begin
                            if (w_gap_tc) begin
                                if (miss_cnt_q == LOSS_LAST_M1) begin
                                    lost_d     = 1'b1;
                                    state_d    = HUNT;
                                    miss_cnt_d = '0;
                                end else begin
                                    miss_cnt_d = miss_cnt_q + 1'b1;
                                end
                            end
                            // The byte that triggers loss of lock is dropped.
                            if (!lost_d) begin
                                valid_d = 1'b1;
                                data_d  = byte_in;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q    <= IDLE;
            com_cnt_q  <= '0;
            miss_cnt_q <= '0;
            slip_q     <= 1'b0;
            lost_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            com_cnt_q  <= com_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            slip_q     <= slip_d;
            lost_q     <= lost_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
        end
    end

    assign active    = (state_q == LOCKED);
    assign slip_req  = slip_q;
    assign lock_lost = lost_q;
    assign valid_out = valid_q;
    assign data_out  = data_q;

`ifdef RX_SYNC_STATS_EN
    logic [7:0] slip_cnt_q;
    logic [7:0] loss_cnt_q;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            slip_cnt_q <= 8'h00;
            loss_cnt_q <= 8'h00;
        end else begin
            if (slip_d && (slip_cnt_q != 8'hFF)) begin
                slip_cnt_q <= slip_cnt_q + 8'h01;
            end
            if (lost_d && (loss_cnt_q != 8'hFF)) begin
                loss_cnt_q <= loss_cnt_q + 8'h01;
            end
        end
    end

    assign slip_cnt = slip_cnt_q;
    assign loss_cnt = loss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_lane_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_lane_sync_ctrl
//  Description : Self-checking bench for rx_lane_sync_ctrl: directed scenarios
//                followed by randomized traffic against a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_lane_sync_ctrl;

    localparam int ACQ = 4;
    localparam int HTO = 16;
    localparam int CI  = 64;
    localparam int LC  = 3;

    logic       clk_4f     = 1'b0;
    logic       reset      = 1'b1;
    logic       rx_enable  = 1'b0;
    logic [7:0] byte_in    = 8'h00;
    logic       byte_valid = 1'b0;
    logic       slip_req;
    logic       active;
    logic [7:0] data_out;
    logic       valid_out;
    logic       lock_lost;
`ifdef RX_SYNC_STATS_EN
    logic [7:0] slip_cnt;
    logic [7:0] loss_cnt;
    int         m_slips  = 0;
    int         m_losses = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Observed pulse tallies for scenario-level checks.
    int n_slip  = 0;
    int n_valid = 0;
    int n_lost  = 0;

    // Reference model: mode 0 idle, 1 hunt, 2 acquire, 3 locked.
    // run = non-COM bytes since last COM/slip (hunt), COM run length
    // (acquire), or non-COM bytes since last COM (locked).
    int         m_mode = 0;
    int         m_run  = 0;
    logic       e_slip  = 1'b0;
    logic       e_lost  = 1'b0;
    logic       e_valid = 1'b0;
    logic [7:0] e_data  = 8'h00;

    always #5 clk_4f = ~clk_4f;

    rx_lane_sync_ctrl #(
        .ACQ_COUNT    (ACQ),
        .HUNT_TIMEOUT (HTO),
        .COM_INTERVAL (CI),
        .LOSS_COUNT   (LC)
    ) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .rx_enable  (rx_enable),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .slip_req   (slip_req),
        .active     (active),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .lock_lost  (lock_lost)
`ifdef RX_SYNC_STATS_EN
        ,
        .slip_cnt   (slip_cnt),
        .loss_cnt   (loss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        e_slip  = 1'b0;
        e_lost  = 1'b0;
        e_valid = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_run  = 0;
            e_data = 8'h00;
`ifdef RX_SYNC_STATS_EN
            m_slips  = 0;
            m_losses = 0;
`endif
        end else if (!rx_enable) begin
            m_mode = 0;
            m_run  = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_run  = 0;
        end else if (byte_valid) begin
            if (m_mode == 1) begin
                if (byte_in == 8'hBC) begin
                    m_run  = (ACQ == 1) ? 0 : 1;
                    m_mode = (ACQ == 1) ? 3 : 2;
                end else begin
                    m_run++;
                    if (m_run == HTO) begin
                        e_slip = 1'b1;
                        m_run  = 0;
                    end
                end
            end else if (m_mode == 2) begin
                if (byte_in == 8'hBC) begin
                    m_run++;
                    if (m_run == ACQ) begin
                        m_mode = 3;
                        m_run  = 0;
                    end
                end else begin
                    m_mode = 1;
                    m_run  = 0;
                end
            end else begin
                if (byte_in == 8'hBC) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == CI * LC) begin
                        e_lost = 1'b1;
                        m_mode = 1;
                        m_run  = 0;
                    end else begin
                        e_valid = 1'b1;
                        e_data  = byte_in;
                    end
                end
            end
        end
`ifdef RX_SYNC_STATS_EN
        if (e_slip && m_slips < 255)  m_slips++;
        if (e_lost && m_losses < 255) m_losses++;
`endif
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs checked 1 ns later.
    task automatic cycle();
        @(posedge clk_4f);
        model_step();
        #1;
        check("slip_req", slip_req, e_slip);
        check("active", active, (m_mode == 3));
        check("valid_out", valid_out, e_valid);
        check("lock_lost", lock_lost, e_lost);
        check("data_out", data_out, e_data);
`ifdef RX_SYNC_STATS_EN
        check("slip_cnt", slip_cnt, m_slips);
        check("loss_cnt", loss_cnt, m_losses);
`endif
        if (slip_req === 1'b1)  n_slip++;
        if (valid_out === 1'b1) n_valid++;
        if (lock_lost === 1'b1) n_lost++;
    endtask

    task automatic send(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            byte_in    = b;
            byte_valid = 1'b1;
            cycle();
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_data(input int n);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = 8'(i + 1);
            if (v == 8'hBC) v = 8'h11;
            send(v, 1);
        end
    endtask

    task automatic clr_tally();
        n_slip  = 0;
        n_valid = 0;
        n_lost  = 0;
    endtask

    // Pass through IDLE into a fresh HUNT.
    task automatic restart_hunt();
        byte_valid = 1'b0;
        rx_enable  = 1'b0;
        cycle();
        rx_enable  = 1'b1;
        cycle();
    endtask

    task automatic relock();
        restart_hunt();
        send(8'hBC, ACQ);
    endtask

    initial begin
        int p_com;

        // Reset state
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("reset_active", active, 1'b0);
        reset = 1'b0;

        // Clean acquisition
        restart_hunt();
        clr_tally();
        send(8'hBC, ACQ);
        check("clean_active", active, 1'b1);
        send(8'h55, 1);
        check("clean_data", data_out, 8'h55);
        check("clean_valid", valid_out, 1'b1);
        check("clean_slips", n_slip, 0);

        // Slip hunting
        restart_hunt();
        clr_tally();
        send(8'h3C, HTO);
        check("slip_first", slip_req, 1'b1);
        send(8'h3C, HTO);
        check("slip_two", n_slip, 2);

        // Broken acquisition
        restart_hunt();
        send(8'hBC, 2);
        send(8'h00, 1);
        check("broken_active", active, 1'b0);
        send(8'hBC, ACQ - 1);
        check("broken_not_yet", active, 1'b0);
        send(8'hBC, 1);
        check("broken_locked", active, 1'b1);

        // Loss of lock
        relock();
        clr_tally();
        send_data(CI * LC);
        check("loss_fwd", n_valid, CI * LC - 1);
        check("loss_pulse", n_lost, 1);
        check("loss_active", active, 1'b0);

        // Loss variant: COM at byte 150
        relock();
        clr_tally();
        send_data(149);
        send(8'hBC, 1);
        send_data(CI * LC - 1);
        check("var_no_loss", n_lost, 0);
        send_data(1);
        check("var_loss", n_lost, 1);

        // Filler removal
        relock();
        clr_tally();
        for (int i = 0; i < 20; i++) begin
            send(8'hBC, 1);
            check("filler_valid", valid_out, 1'b0);
            send(8'(8'h40 + i), 1);
            check("filler_data", data_out, 8'(8'h40 + i));
        end
        check("filler_count", n_valid, 20);

        // Disable while locked, with a colliding byte
        relock();
        send_data(3);
        clr_tally();
        rx_enable  = 1'b0;
        byte_in    = 8'h77;
        byte_valid = 1'b1;
        cycle();
        byte_valid = 1'b0;
        check("dis_active", active, 1'b0);
        check("dis_valid", valid_out, 1'b0);
        check("dis_lost", n_lost, 0);

        // Reset mid-HUNT
        restart_hunt();
        clr_tally();
        send(8'h3C, 10);
        reset      = 1'b1;
        byte_in    = 8'h3C;
        byte_valid = 1'b1;
        cycle();
        reset = 1'b0;
        send(8'h3C, 10);
        check("rst_no_slip", n_slip, 0);

`ifdef RX_SYNC_STATS_EN
        // Slip counter saturation
        restart_hunt();
        send(8'h3C, 300 * HTO);
        check("slip_cnt_sat", slip_cnt, 8'hFF);
`endif

        // Randomized traffic
        p_com = 50;
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ((i % 40) == 0) p_com = ($urandom_range(0, 1) == 0) ? 50 : 1;
            r          = $urandom_range(0, 999);
            reset      = (r < 2);
            rx_enable  = !(r >= 2 && r < 6);
            byte_valid = ($urandom_range(0, 9) < 8);
            byte_in    = ($urandom_range(0, 99) < p_com) ? 8'hBC : 8'($urandom);
            cycle();
        end
        reset      = 1'b0;
        byte_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_lane_sync_ctrl.md
Name: rx_lane_sync_ctrl

Overview:
Byte-rate controller that sequences the serial-to-parallel receive lane. It consumes bytes from the deserializer and hunts for COM (8'hBC) alignment, requesting bit slips until alignment is found. It declares the lane active after a run of consecutive COMs and forwards payload bytes. It monitors COM recurrence and drops lock when COMs stop arriving. It sits between the deserializer and the lane-level receive logic.

Parameters:
COM_SYMBOL, 8'hBC, alignment/filler symbol
ACQ_COUNT, 4, consecutive COMs required to enter LOCKED (1..15)
HUNT_TIMEOUT, 16, bytes without any COM in HUNT before a slip is requested (2..255)
COM_INTERVAL, 64, max bytes between COMs while LOCKED (2..255)
LOSS_COUNT, 3, consecutive missed COM intervals that cause loss of lock (1..7)

Ports:
clk_4f  in  1  byte-rate clock
reset  in  1  synchronous, active-high reset
rx_enable  in  1  lane enable; low forces IDLE
byte_in  in  8  parallel byte from the deserializer
byte_valid  in  1  byte_in qualifier, one cycle per byte
slip_req  out  1  one-cycle pulse; deserializer shifts its alignment by one bit
active  out  1  lane locked
data_out  out  8  forwarded payload byte
valid_out  out  1  data_out qualifier
lock_lost  out  1  one-cycle pulse when LOCKED is exited because COMs were missed

Behaviour:
- Reset is synchronous and active-high. All outputs are 0 in reset, state is IDLE, and all counters are 0.
- Sampling: every state and counter update happens only on cycles where byte_valid=1, except the rx_enable and reset transitions.
- IDLE: entered whenever rx_enable=0, evaluated first, with no other action that cycle. Goes to HUNT on the cycle after rx_enable=1.
- HUNT:
  - A COM byte clears the timer, sets com_cnt=1 and moves to ACQUIRE.
  - A non-COM byte increments the timer.
  - When the timer reaches HUNT_TIMEOUT, slip_req pulses for 1 cycle, the timer clears, and the FSM stays in HUNT.
  - At most one slip is issued per HUNT_TIMEOUT bytes.
- ACQUIRE:
  - A COM byte increments com_cnt. When com_cnt reaches ACQ_COUNT, the FSM moves to LOCKED and active=1 on the next cycle.
  - A non-COM byte clears com_cnt and returns to HUNT; no slip is issued.
- LOCKED:
  - A COM byte is filler: it is not forwarded, valid_out=0, and it clears both the gap counter and miss_cnt.
  - A non-COM byte is forwarded with 1-cycle latency: data_out=byte_in and valid_out=1 on the next cycle. data_out holds its last value otherwise.
  - The gap counter increments per byte. On reaching COM_INTERVAL it clears and miss_cnt increments.
  - When miss_cnt reaches LOSS_COUNT: lock_lost pulses, active=0, valid_out=0, and the FSM goes to HUNT with counters cleared. The byte on that cycle is not forwarded.
- valid_out is never 1 unless active was 1 in the same cycle's registered state.
- If rx_enable falls in LOCKED: active=0 and valid_out=0 next cycle, and no lock_lost pulse.
- If rx_enable falls and byte_valid=1 in the same cycle, rx_enable wins and the byte is dropped.
- If reset is asserted mid-operation, everything clears next edge with no pulses.
- Counter widths: each counter is just wide enough for its parameter and never wraps; it is compared, then cleared.

Optional Feature:
- Macro: RX_SYNC_STATS_EN.
- When defined, adds two outputs:
  - slip_cnt[7:0]: increments on each slip_req.
  - loss_cnt[7:0]: increments on each lock_lost.
  - Both saturate at 8'hFF and are cleared only by reset.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package pcie_phy_pkg holds:
  - COM_SYMBOL.
  - The state enum (IDLE=0, HUNT=1, ACQUIRE=2, LOCKED=3), 2 bits.
- One sub-module, rx_sym_timer: a byte-qualified up-counter with terminal pulse and synchronous clear. It is instantiated for the HUNT timeout and for the LOCKED COM interval.

Test Plan:
- Clean acquisition:
  - Stimulus: rx_enable=1, then 4 × 8'hBC, then 8'h55.
  - Expected: active=1 after the 4th COM; data_out=8'h55, valid_out=1 one cycle after the 8'h55 byte; no slip_req.
- Slip hunting:
  - Stimulus: 16 non-COM bytes (8'h3C).
  - Expected: one slip_req pulse after the 16th byte; 32 bytes produce exactly 2 pulses.
- Broken acquisition:
  - Stimulus: BC, BC, 8'h00, then 4 × BC.
  - Expected: return to HUNT on 8'h00; active=1 only after the later 4 COMs.
- Loss of lock (defaults):
  - Stimulus: lock, then 192 non-COM bytes.
  - Expected: lock_lost pulse and active=0 after byte 192; all 191 earlier bytes forwarded.
  - Variant: a COM at byte 150 clears miss_cnt, so no loss occurs before byte 342.
- Filler removal: interleave BC and data in LOCKED → valid_out=0 for every BC and all data bytes forwarded in order.
- Disable/reset:
  - rx_enable low while LOCKED → active=0 next cycle, no lock_lost.
  - reset high mid-HUNT → no slip_req.
  - With RX_SYNC_STATS_EN: slip_cnt saturates at 255 after 300 slips.
